// File: rtl/serial_adder_if.sv
// ----------------------------------------------------------------------------
// serial_adder_if
// Handshake and data bundle for the bit-serial adder.
//   start      : request to begin an addition (requester -> adder)
//   a, b, cin  : operands and carry-in, captured when start is accepted
//   sum, cout  : registered result, held until the next completion or reset
//   busy       : addition in progress
//   done       : one-cycle pulse, sum/cout valid during it
// Modports: master = requester side, slave = adder side.
// ----------------------------------------------------------------------------
interface serial_adder_if #(
    parameter int WIDTH = 8
) ();
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;
    logic             done;

    modport master (
        output start, a, b, cin,
        input  sum, cout, busy, done
    );

    modport slave (
        input  start, a, b, cin,
        output sum, cout, busy, done
    );
endinterface

// File: rtl/serial_adder.sv
// ----------------------------------------------------------------------------
// serial_adder
// Bit-serial adder: computes a + b + cin one bit per clock, LSB first, with a
// three-state FSM (IDLE -> ADD -> DONE). An addition takes WIDTH ADD cycles
// followed by a single DONE cycle in which done pulses.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset, clears all state
//   bus  : serial_adder_if.slave (start/a/b/cin in, sum/cout/busy/done out)
// ----------------------------------------------------------------------------
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst,
    serial_adder_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] s_sr;
    logic             carry;
    logic [CNT_W-1:0] bit_cnt;

    logic [WIDTH-1:0] sum_r;
    logic             cout_r;
    logic             busy_r;
    logic             done_r;

    logic             s_bit;
    logic             c_next;
    logic [WIDTH-1:0] s_shifted;
    logic             last_bit;

    function automatic logic [1:0] full_add(input logic x, input logic y, input logic c);
        full_add = {(x & y) | (x & c) | (y & c), x ^ y ^ c};
    endfunction

    always_comb begin
        {c_next, s_bit} = full_add(a_sr[0], b_sr[0], carry);
        s_shifted       = {s_bit, s_sr[WIDTH-1:1]};
        last_bit        = (bit_cnt == CNT_W'(WIDTH - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            a_sr    <= '0;
            b_sr    <= '0;
            s_sr    <= '0;
            carry   <= 1'b0;
            bit_cnt <= '0;
            sum_r   <= '0;
            cout_r  <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        a_sr    <= bus.a;
                        b_sr    <= bus.b;
                        carry   <= bus.cin;
                        bit_cnt <= '0;
                        busy_r  <= 1'b1;
                        state   <= ADD;
                    end else begin
                        busy_r  <= 1'b0;
                        state   <= IDLE;
                    end
                end
                ADD: begin
                    // start is deliberately not looked at here.
                    a_sr    <= a_sr >> 1;
                    b_sr    <= b_sr >> 1;
                    s_sr    <= s_shifted;
                    carry   <= c_next;
                    bit_cnt <= bit_cnt + 1'b1;
                    if (last_bit) begin
                        // Take the final sum bit and carry straight from the
                        // adder so the result appears together with done.
                        sum_r  <= s_shifted;
                        cout_r <= c_next;
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                        state  <= DONE;
                    end
                end
                default: begin
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.sum  = sum_r;
    assign bus.cout = cout_r;
    assign bus.busy = busy_r;
    assign bus.done = done_r;
endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter: WIDTH, default 8, operand and sum width in bits; legal range 2..32.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset; clears all state immediately on assertion, independent of clk.
REQ-004 start  input  1  request to begin an addition; sampled on the rising clk edge.
REQ-005 a  input  WIDTH  operand A; sampled only on the edge that accepts start.
REQ-006 b  input  WIDTH  operand B; sampled only on the edge that accepts start.
REQ-007 cin  input  1  carry-in; sampled only on the edge that accepts start.
REQ-008 sum  output  WIDTH  result A+B+cin modulo 2^WIDTH; registered.
REQ-009 cout  output  1  carry out of bit WIDTH-1; registered.
REQ-010 busy  output  1  high while the addition is in progress.
REQ-011 done  output  1  one-cycle pulse; sum and cout are valid during this cycle.

Function
REQ-012 The block SHALL be a three-state FSM: IDLE, ADD, DONE.
REQ-013 In IDLE or DONE, start=1 SHALL be accepted on that edge: a, b and cin latched into internal shift registers and a carry flip-flop, bit counter cleared to 0, next state ADD.
REQ-014 In ADD, each edge SHALL process exactly one bit, LSB first: s_i = a_i ^ b_i ^ c, c_next = a_i&b_i | a_i&c | b_i&c, with c the carry flip-flop; the full_adder module may be instantiated for this logic.
REQ-015 Each ADD edge SHALL shift the operand registers right by one bit, shift s_i into the MSB of the sum shift register, and increment the bit counter.
REQ-016 On the edge that processes bit WIDTH-1, the block SHALL load the sum and cout outputs from the shift register and the final carry, and move to DONE.
REQ-017 Latency: with start accepted on edge k, busy SHALL be high from edge k through edge k+WIDTH-1, and done SHALL be high from edge k+WIDTH until edge k+WIDTH+1.
REQ-018 DONE SHALL last exactly one cycle; next state is ADD if start=1, otherwise IDLE.
REQ-019 start SHALL be ignored in ADD; operands, counter and carry are unaffected.
REQ-020 sum and cout SHALL hold their last result through IDLE and through a subsequent ADD; they change only on the completing edge (REQ-016) or on reset.
REQ-021 Changes on a, b or cin after acceptance SHALL NOT affect the result in progress.
REQ-022 busy and done SHALL never be high in the same cycle.
REQ-023 Arithmetic SHALL wrap: the result equals (a+b+cin) mod 2^WIDTH, with cout = bit WIDTH of the full sum.

Reset
REQ-024 While rst=1: state=IDLE, sum=0, cout=0, busy=0, done=0, and the counter, carry flip-flop and shift registers are 0.
REQ-025 Reset asserted during ADD SHALL abort the operation with no done pulse; sum and cout read 0.
REQ-026 After rst deasserts, the first edge with start=1 SHALL be accepted normally.

Verification
REQ-027 WIDTH=8, a=8'hFF, b=8'h01, cin=0, start pulsed on edge 0 -> busy high on edges 0..7; done high at edge 8; sum=8'h00, cout=1.
REQ-028 a=8'h00, b=8'h00, cin=1 -> sum=8'h01, cout=0; a=8'hA5, b=8'h5A, cin=0 -> sum=8'hFF, cout=0; a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1.
REQ-029 start pulsed mid-ADD with new operands -> ignored; original result delivered at the original done cycle.
REQ-030 start held high through DONE with a=8'h03, b=8'h04 -> second addition accepted in the done cycle; next done exactly 8 cycles later with sum=8'h07.
REQ-031 rst pulsed asynchronously (between clock edges) at bit 4 of an ADD -> outputs 0 immediately; no done pulse; a fresh start yields the correct sum.
REQ-032 Exhaustive check with WIDTH=4 over all a, b, cin -> every {cout, sum} equals a+b+cin.
